// File: rtl/lim_data_responder.sv
// Memory-side responder for the core data port with logic-in-memory sideband.
// Plain accesses answer in one cycle; LIM stores run a range read-modify-write engine.
module lim_data_responder #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MAX_RANGE  = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    input  logic        data_logic_in_memory_i,
    input  logic [2:0]  data_opcode_mem_i,
    input  logic [31:0] data_asize_mem_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        busy_o
);

    localparam int unsigned IDX_W = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH = 2 ** IDX_W;
    localparam int unsigned CNT_W = (MAX_RANGE > 1) ? $clog2(MAX_RANGE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RANGE,
        S_RESP
    } state_e;

    state_e             state_q;
    logic               rvalid_q;
    logic [31:0]        rdata_q;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   last_q;
    logic [IDX_W-1:0]   base_q;
    logic [31:0]        operand_q;
    logic [3:0]         be_q;
    logic [2:0]         opc_q;

    logic [31:0]        mem_q [DEPTH];

    logic [IDX_W-1:0]   addr_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic [31:0]        rd_word;
    logic [2:0]         op_sel;
    logic [31:0]        op_b;
    logic [31:0]        op_word;
    logic               mem_we;
    logic [31:0]        mem_wdata;
    logic [CNT_W-1:0]   last_d;
    logic               unused_addr;

    function automatic logic [31:0] lim_op(input logic [2:0] opc,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        case (opc)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a ^ b;
            3'b011:  return ~(a & b);
            3'b100:  return ~(a | b);
            3'b101:  return ~(a ^ b);
            default: return b;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (new_w & mask) | (old_w & ~mask);
    endfunction

    assign unused_addr = ^{data_addr_i[31:ADDR_WIDTH], data_addr_i[1:0]};
    assign addr_idx    = data_addr_i[ADDR_WIDTH-1:2];

    assign data_gnt_o    = (state_q == S_IDLE) & data_req_i & ~stall_i & ~rst_i;
    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign busy_o        = busy_q;

    // One shared read port: the range engine owns it while active, else the request does.
    always_comb begin
        rd_idx    = addr_idx;
        op_sel    = data_opcode_mem_i;
        op_b      = data_wdata_i;
        if (state_q == S_RANGE) begin
            rd_idx = base_q + IDX_W'(cnt_q);
            op_sel = opc_q;
            op_b   = operand_q;
        end
        rd_word   = mem_q[rd_idx];
        op_word   = lim_op(op_sel, rd_word, op_b);
        mem_we    = 1'b0;
        mem_wdata = merge(rd_word, op_word, be_q);
        if (state_q == S_RANGE) begin
            mem_we = ~rst_i;
        end else if (data_gnt_o && data_we_i && !data_logic_in_memory_i) begin
            mem_we    = 1'b1;
            mem_wdata = merge(rd_word, data_wdata_i, data_be_i);
        end
    end

    // Range length as last word offset: asize 0 means one word, clamped to MAX_RANGE.
    always_comb begin
        last_d = '0;
        if (data_asize_mem_i == 32'd0) begin
            last_d = '0;
        end else if (data_asize_mem_i > 32'(MAX_RANGE)) begin
            last_d = CNT_W'(MAX_RANGE - 1);
        end else begin
            last_d = CNT_W'(data_asize_mem_i - 32'd1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[rd_idx] <= mem_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (data_gnt_o) begin
                        if (data_logic_in_memory_i && data_we_i) begin
                            base_q    <= addr_idx;
                            operand_q <= data_wdata_i;
                            be_q      <= data_be_i;
                            opc_q     <= data_opcode_mem_i;
                            last_q    <= last_d;
                            cnt_q     <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= S_RANGE;
                        end else begin
                            rvalid_q <= 1'b1;
                            if (data_we_i) begin
                                rdata_q <= 32'd0;
                            end else if (data_logic_in_memory_i) begin
                                rdata_q <= op_word;
                            end else begin
                                rdata_q <= rd_word;
                            end
                        end
                    end
                end
                S_RANGE: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == last_q) begin
                        busy_q  <= 1'b0;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= 32'd0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lim_data_responder.sv
// Directed self-checking bench for lim_data_responder: pipelined vector table
// plus hand-written range, wrap, stall and reset sequences.
module tb_lim_data_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_logic_in_memory_i;
    logic [2:0]  data_opcode_mem_i;
    logic [31:0] data_asize_mem_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    lim_data_responder dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .stall_i                (stall_i),
        .data_req_i             (data_req_i),
        .data_addr_i            (data_addr_i),
        .data_we_i              (data_we_i),
        .data_be_i              (data_be_i),
        .data_wdata_i           (data_wdata_i),
        .data_logic_in_memory_i (data_logic_in_memory_i),
        .data_opcode_mem_i      (data_opcode_mem_i),
        .data_asize_mem_i       (data_asize_mem_i),
        .data_gnt_o             (data_gnt_o),
        .data_rvalid_o          (data_rvalid_o),
        .data_rdata_o           (data_rdata_o),
        .busy_o                 (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic        we;
        logic        lim;
        logic [2:0]  opc;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic lim, input logic [2:0] opc,
                         input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [31:0] asize);
        data_req_i             = 1'b1;
        data_we_i              = we;
        data_logic_in_memory_i = lim;
        data_opcode_mem_i      = opc;
        data_addr_i            = addr;
        data_be_i              = be;
        data_wdata_i           = wdata;
        data_asize_mem_i       = asize;
    endtask

    // Single non-range transaction; starts and ends on a falling edge.
    task automatic txn(input string name, input logic we, input logic lim, input logic [2:0] opc,
                       input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input logic [31:0] exp);
        drive(we, lim, opc, addr, be, wdata, 32'd0);
        #1;
        check({name, "_gnt"}, 32'(data_gnt_o), 32'd1);
        @(negedge clk_i);
        data_req_i = 1'b0;
        check({name, "_rvalid"}, 32'(data_rvalid_o), 32'd1);
        check({name, "_rdata"}, data_rdata_o, exp);
    endtask

    task automatic st(input logic [31:0] addr, input logic [31:0] wdata);
        txn("store", 1'b1, 1'b0, 3'd0, addr, 4'hF, wdata, 32'd0);
    endtask

    task automatic ld(input string name, input logic [31:0] addr, input logic [31:0] exp);
        txn(name, 1'b0, 1'b0, 3'd0, addr, 4'hF, 32'd0, exp);
    endtask

    // LIM range store: checks grant, busy length, response latency and no grant while active.
    task automatic lim_range(input string name, input logic [2:0] opc, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wdata,
                             input logic [31:0] asize, input int exp_n);
        int busy_n = 0;
        int rv_at = -1;
        int rv_n = 0;
        int gnt_n = 0;
        logic [31:0] rv_data = 32'hFFFF_FFFF;
        drive(1'b1, 1'b1, opc, addr, be, wdata, asize);
        #1;
        check({name, "_gnt"}, 32'(data_gnt_o), 32'd1);
        @(negedge clk_i);
        for (int c = 0; c <= exp_n + 3; c++) begin
            if (c <= exp_n) begin
                drive(1'b0, 1'b0, 3'd0, 32'h0000_0FF0 + 32'(c), 4'hF, 32'(c), 32'd0);
            end else begin
                data_req_i = 1'b0;
            end
            #1;
            if (busy_o) busy_n++;
            if (data_gnt_o) gnt_n++;
            if (data_rvalid_o) begin
                rv_n++;
                if (rv_at < 0) begin
                    rv_at = c;
                    rv_data = data_rdata_o;
                end
            end
            @(negedge clk_i);
        end
        check({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_n));
        check({name, "_rvalid_latency"}, 32'(rv_at), 32'(exp_n + 1));
        check({name, "_rvalid_count"}, 32'(rv_n), 32'd1);
        check({name, "_gnt_while_busy"}, 32'(gnt_n), 32'd0);
        check({name, "_rdata"}, rv_data, 32'd0);
    endtask

    initial begin
        int rv_n;

        vecs[0]  = '{1'b1, 1'b0, 3'd0, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[1]  = '{1'b0, 1'b0, 3'd0, 32'h0000_0010, 4'hF, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b0, 3'd0, 32'h0000_0010, 4'h5, 32'h1122_3344, 32'h0000_0000};
        vecs[3]  = '{1'b0, 1'b0, 3'd0, 32'h0000_0010, 4'hF, 32'h0000_0000, 32'hDE22_BE44};
        vecs[4]  = '{1'b0, 1'b1, 3'd0, 32'h0000_0010, 4'h0, 32'hFF00_FF00, 32'hDE00_BE00};
        vecs[5]  = '{1'b0, 1'b1, 3'd3, 32'h0000_0010, 4'hF, 32'hFFFF_FFFF, 32'h21DD_41BB};
        vecs[6]  = '{1'b0, 1'b1, 3'd7, 32'h0000_0010, 4'hF, 32'h1234_5678, 32'h1234_5678};
        vecs[7]  = '{1'b0, 1'b0, 3'd0, 32'h0000_0010, 4'hF, 32'h0000_0000, 32'hDE22_BE44};
        vecs[8]  = '{1'b1, 1'b0, 3'd0, 32'h0001_0014, 4'hF, 32'hCAFE_F00D, 32'h0000_0000};
        vecs[9]  = '{1'b0, 1'b0, 3'd0, 32'h0000_0017, 4'hF, 32'h0000_0000, 32'hCAFE_F00D};
        vecs[10] = '{1'b0, 1'b1, 3'd1, 32'h0000_0014, 4'hF, 32'h0000_0100, 32'hCAFE_F10D};
        vecs[11] = '{1'b0, 1'b1, 3'd2, 32'h0000_0014, 4'hF, 32'hFFFF_0000, 32'h3501_F00D};
        vecs[12] = '{1'b0, 1'b1, 3'd4, 32'h0000_0014, 4'hF, 32'h0000_0000, 32'h3501_0FF2};
        vecs[13] = '{1'b0, 1'b1, 3'd5, 32'h0000_0014, 4'hF, 32'h0F0F_0F0F, 32'h3A0E_00FD};
        vecs[14] = '{1'b0, 1'b1, 3'd6, 32'h0000_0014, 4'hF, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
        vecs[15] = '{1'b0, 1'b0, 3'd0, 32'h0000_0014, 4'hF, 32'h0000_0000, 32'hCAFE_F00D};

        // Reset with a request pending: reset must win.
        rst_i   = 1'b1;
        stall_i = 1'b0;
        drive(1'b1, 1'b0, 3'd0, 32'h0000_0010, 4'hF, 32'h0BAD_0BAD, 32'd0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_gnt", 32'(data_gnt_o), 32'd0);
        check("reset_rvalid", 32'(data_rvalid_o), 32'd0);
        check("reset_rdata", data_rdata_o, 32'd0);
        check("reset_busy", 32'(busy_o), 32'd0);
        rst_i      = 1'b0;
        data_req_i = 1'b0;
        @(negedge clk_i);

        // Back-to-back table: response k is checked while request k+1 is granted.
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) begin
                drive(vecs[i].we, vecs[i].lim, vecs[i].opc, vecs[i].addr,
                      vecs[i].be, vecs[i].wdata, 32'd0);
            end else begin
                data_req_i = 1'b0;
            end
            #1;
            if (i < NV) check($sformatf("vec%0d_gnt", i), 32'(data_gnt_o), 32'd1);
            if (i > 0) begin
                check($sformatf("vec%0d_rvalid", i - 1), 32'(data_rvalid_o), 32'd1);
                check($sformatf("vec%0d_rdata", i - 1), data_rdata_o, vecs[i - 1].exp);
            end
            @(negedge clk_i);
        end

        // Range XOR over words 4..7, word 8 must survive.
        for (int w = 4; w < 8; w++) st(32'(w * 4), 32'h0F0F_0F0F);
        st(32'h0000_0020, 32'h5555_5555);
        lim_range("xor4", 3'd2, 32'h0000_0010, 4'hF, 32'hFFFF_FFFF, 32'd4, 4);
        for (int w = 4; w < 8; w++) ld($sformatf("xor4_word%0d", w), 32'(w * 4), 32'hF0F0_F0F0);
        ld("xor4_word8", 32'h0000_0020, 32'h5555_5555);

        // Last word: asize 0 touches one word, asize 2 wraps to word 0.
        st(32'h0000_FFFC, 32'hAAAA_0000);
        st(32'h0000_0000, 32'h0000_AAAA);
        st(32'h0000_0004, 32'h1212_1212);
        lim_range("asize0", 3'd1, 32'h0000_FFFC, 4'hF, 32'h0000_FFFF, 32'd0, 1);
        ld("asize0_last", 32'h0000_FFFC, 32'hAAAA_FFFF);
        ld("asize0_word0", 32'h0000_0000, 32'h0000_AAAA);
        lim_range("wrap", 3'd6, 32'h0000_FFFC, 4'h3, 32'h7777_7777, 32'd2, 2);
        ld("wrap_last", 32'h0000_FFFC, 32'hAAAA_7777);
        ld("wrap_word0", 32'h0000_0000, 32'h0000_7777);
        ld("wrap_word1", 32'h0000_0004, 32'h1212_1212);

        // Oversized asize clamps to 256 words.
        st(32'h0000_0800, 32'h0000_0000);
        st(32'h0000_0BFC, 32'h0000_0000);
        st(32'h0000_0C00, 32'h0000_0000);
        lim_range("clamp", 3'd2, 32'h0000_0800, 4'hF, 32'h0000_0001, 32'h0001_0000, 256);
        ld("clamp_first", 32'h0000_0800, 32'h0000_0001);
        ld("clamp_last", 32'h0000_0BFC, 32'h0000_0001);
        ld("clamp_after", 32'h0000_0C00, 32'h0000_0000);

        // Stall withholds grant; the request present at the granting edge is used.
        st(32'h0000_0040, 32'h0000_0000);
        st(32'h0000_0044, 32'h9999_9999);
        stall_i = 1'b1;
        drive(1'b1, 1'b0, 3'd0, 32'h0000_0040, 4'hF, 32'h1111_1111, 32'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("stall%0d_gnt", k), 32'(data_gnt_o), 32'd0);
            @(negedge clk_i);
        end
        stall_i      = 1'b0;
        data_addr_i  = 32'h0000_0044;
        data_wdata_i = 32'h2222_2222;
        #1;
        check("unstall_gnt", 32'(data_gnt_o), 32'd1);
        @(negedge clk_i);
        data_req_i = 1'b0;
        check("unstall_rvalid", 32'(data_rvalid_o), 32'd1);
        ld("stall_word40", 32'h0000_0040, 32'h0000_0000);
        ld("stall_word44", 32'h0000_0044, 32'h2222_2222);

        // Reset after two of six range words.
        for (int w = 0; w < 7; w++) st(32'h0000_0400 + 32'(w * 4), 32'h3333_3333);
        ld("rst_pre", 32'h0000_0400, 32'h3333_3333);
        drive(1'b1, 1'b1, 3'd2, 32'h0000_0400, 4'hF, 32'hFFFF_FFFF, 32'd6);
        #1;
        check("rstmid_gnt", 32'(data_gnt_o), 32'd1);
        @(negedge clk_i);
        data_req_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rstmid_rvalid", 32'(data_rvalid_o), 32'd0);
        check("rstmid_busy", 32'(busy_o), 32'd0);
        check("rstmid_rdata", data_rdata_o, 32'd0);
        drive(1'b0, 1'b0, 3'd0, 32'h0000_0400, 4'hF, 32'd0, 32'd0);
        #1;
        check("rstmid_req_gnt", 32'(data_gnt_o), 32'd0);
        @(negedge clk_i);
        rst_i      = 1'b0;
        data_req_i = 1'b0;
        rv_n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            if (data_rvalid_o) rv_n++;
        end
        check("rstmid_no_rvalid", 32'(rv_n), 32'd0);
        ld("rstmid_word0", 32'h0000_0400, 32'hCCCC_CCCC);
        ld("rstmid_word1", 32'h0000_0404, 32'hCCCC_CCCC);
        for (int w = 2; w < 7; w++)
            ld($sformatf("rstmid_word%0d", w), 32'h0000_0400 + 32'(w * 4), 32'h3333_3333);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
